// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store sequencer for the single-port data RAM with RMW sub-word stores
module data_mem_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t                    state;
  logic                      we_q;
  logic [2:0]                f3_q;
  logic [1:0]                addr_lo;
  logic [2*BYTE_WIDTH-1:0]   wdata_lo;

  logic                      f3_ok;
  logic                      align_ok;
  logic                      req_err;
  logic [4:0]                lane_shift;
  logic [DATA_WIDTH-1:0]     lane_data;
  logic [BYTE_WIDTH-1:0]     byte_v;
  logic [2*BYTE_WIDTH-1:0]   half_v;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic [DATA_WIDTH-1:0]     lane_mask;
  logic [DATA_WIDTH-1:0]     lane_wdata;
  logic [DATA_WIDTH-1:0]     merged;

  // Classify the incoming request: legal funct3 for its direction and natural alignment for its size
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    if (req_we) begin
      f3_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      f3_ok = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
    end
    case (req_funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    req_err = !(f3_ok && align_ok);
  end

  // Lane extraction and extension for loads; sub-word merge into the read word for stores
  always_comb begin
    lane_shift = {addr_lo, 3'b000};
    lane_data  = mem_rdata >> lane_shift;
    byte_v     = lane_data[BYTE_WIDTH-1:0];
    half_v     = lane_data[2*BYTE_WIDTH-1:0];
    case (f3_q)
      3'b000:  ld_data = {{(DATA_WIDTH-BYTE_WIDTH){byte_v[BYTE_WIDTH-1]}}, byte_v};
      3'b100:  ld_data = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, byte_v};
      3'b001:  ld_data = {{(DATA_WIDTH-2*BYTE_WIDTH){half_v[2*BYTE_WIDTH-1]}}, half_v};
      3'b101:  ld_data = {{(DATA_WIDTH-2*BYTE_WIDTH){1'b0}}, half_v};
      default: ld_data = lane_data;
    endcase
    // half stores are 2-byte aligned, so the same byte-granular shift places them correctly
    lane_mask  = (f3_q[0] ? DATA_WIDTH'({(2*BYTE_WIDTH){1'b1}})
                          : DATA_WIDTH'({BYTE_WIDTH{1'b1}})) << lane_shift;
    lane_wdata = (f3_q[0] ? DATA_WIDTH'(wdata_lo)
                          : DATA_WIDTH'(wdata_lo[BYTE_WIDTH-1:0])) << lane_shift;
    merged     = (mem_rdata & ~lane_mask) | (lane_wdata & lane_mask);
  end

  // Request/response sequencer; every output is a register updated on state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_lo    <= 2'b00;
      wdata_lo   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_lo    <= req_addr[1:0];
            wdata_lo   <= req_wdata[2*BYTE_WIDTH-1:0];
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[ADDRESS_WIDTH-1:2];
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= req_addr[ADDRESS_WIDTH-1:2];
              state    <= RD;
            end
          end
        end
        RD: begin
          mem_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (we_q) begin
            mem_wdata <= merged;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            state     <= WR;
          end else begin
            resp_rdata <= ld_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequencing controller for the single-port data memory: accepts one load or store request at a time from the memory stage and performs the aligned word access. Byte and half stores use a read-modify-write sequence. Loads are returned with sign or zero extension. The block sits between the pipeline's memory stage and the data RAM. It replaces the per-cycle combinational byte merge with an FSM that has explicit request and response handshakes plus a misalignment error path.

## Interface
- DATA_WIDTH, 32, word width (fixed at 32 for RV32)
- BYTE_WIDTH, 8, lane width
- ADDRESS_WIDTH, 9, byte-address width; RAM word index is ADDRESS_WIDTH-2 bits

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (loads 000/001/010/100/101, stores 000/001/010)
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store source (rs2)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or unsupported funct3
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (only with mem_en)
- mem_addr  out  ADDRESS_WIDTH-2  word index = addr[ADDRESS_WIDTH-1:2]
- mem_wdata  out  DATA_WIDTH  full word to write
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we, funct3, addr, and wdata.
  - Errors go to RESP with err=1.
  - sw goes to WR.
  - sb, sh, and all loads go to RD.
- RD: mem_en=1, mem_we=0, mem_addr=latched word index; go to WAIT.
- WAIT: mem_rdata is valid.
  - Load: select the lane, extend, register into resp_rdata, go to RESP.
  - Store: merge and register into a merge buffer, go to WR.
- Merge rules (bp = addr[1:0]):
  - sb replaces byte bp with wdata[7:0].
  - sh replaces bytes {2*addr[1]+1, 2*addr[1]} with wdata[15:0].
  - Untouched bytes come from mem_rdata.
- WR: mem_en=1, mem_we=1, mem_wdata=merge buffer (sw: wdata unmodified); go to RESP.
- Load extension:
  - lb: sign-extend byte bp.
  - lbu: zero-extend byte bp.
  - lh: sign-extend half addr[1].
  - lhu: zero-extend half addr[1].
  - lw: full word.
- Error conditions:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
  - On any error, no RAM strobe is issued.
- RESP: resp_valid=1 and resp_rdata/resp_err held stable until resp_ready; on handshake go to IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- mem_* outputs are decoded from the registered state and buffers, with no combinational path from req_*.
- Latency is counted from the accept edge (cycle 0) to the first resp_valid cycle:
  - sw: 2 (WR in cycle 1).
  - Load: 3.
  - sb/sh: 4 (RD 1, WAIT 2, WR 3).
  - Error: 1.
- Throughput is at most one request in flight; req_ready=0 from the cycle after acceptance until the cycle after the response handshake.
- Response with resp_ready held high: RESP lasts exactly one cycle; IDLE follows.
- Back-to-back: a request presented during RESP is not accepted until IDLE. A store followed by a load to the same word returns the stored data.
- Reset mid-operation: asynchronous reset forces IDLE immediately and deasserts mem_en/mem_we. A pending WR is dropped (RAM unchanged) and no response is produced.
- req_* inputs may change freely after acceptance; only latched copies are used.

## Test plan
- Preload word 0x04 = 0x11223344; sb addr 0x06, wdata 0xAABBCCDD → one read, one write of 0x11DD3344; resp_valid in cycle 4, resp_err=0, resp_rdata=0.
- Same word after the above: lb 0x06 → 0xFFFFFFDD (cycle 3); lbu 0x06 → 0x000000DD; lhu 0x06 → 0x000011DD.
- sw addr 0x20, wdata 0xDEADBEEF → no read strobe, write in cycle 1, resp in cycle 2; then lh 0x22 → 0xFFFFDEAD and lw 0x20 → 0xDEADBEEF.
- sh addr 0x13 and lw addr 0x21 → resp_err=1 in cycle 1, resp_rdata=0, mem_en never asserted; funct3=011 load → err.
- Hold resp_ready=0 for 3 cycles after a lw response → resp_valid, resp_rdata, and resp_err stable, req_ready=0; release → IDLE next cycle.
- Assert rst_n=0 during WAIT of an sb to 0x04 → mem_we stays 0, word still 0x11223344, all outputs at reset values; a fresh request is accepted after release.
